// File: rtl/switch_stats_monitor_pkg.sv
// Shared definitions for the switch statistics monitor: default sizing,
// the read-select encoding and a popcount helper for target masks.
package packet_pkg;

  localparam int DEFAULT_NUM_PORTS = 4;
  localparam int DEFAULT_CNT_W     = 16;
  localparam int NUM_STATS         = 4;

  typedef enum logic [1:0] {
    SEL_ACCEPTED    = 2'd0,
    SEL_DROPPED     = 2'd1,
    SEL_DROP_COPIES = 2'd2,
    SEL_DELIVERED   = 2'd3
  } stat_sel_e;

  // Masks are zero-extended to 16 bits so one helper covers every legal port count.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/switch_stats_monitor_if.sv
// Event and read-port bundle between the switch fabric and the statistics monitor.
interface switch_stats_monitor_if #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]           valid_in;
  logic [NUM_PORTS*NUM_PORTS-1:0] target_in;
  logic [NUM_PORTS-1:0]           fifo_full;
  logic [NUM_PORTS-1:0]           valid_out;
  logic                           clr;
  logic                           rd_en;
  logic [PORT_W-1:0]              rd_port;
  logic [1:0]                     rd_sel;
  logic                           rd_valid;
  logic [CNT_W-1:0]               rd_data;

  modport master (
    output valid_in, target_in, fifo_full, valid_out, clr, rd_en, rd_port, rd_sel,
    input  rd_valid, rd_data
  );

  modport slave (
    input  valid_in, target_in, fifo_full, valid_out, clr, rd_en, rd_port, rd_sel,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/switch_stats_monitor_stat_counter.sv
// Saturating statistics counter with a variable increment and synchronous clear.
// ovf_o pulses in any cycle where the increment would have carried past the maximum.
module stat_counter #(
  parameter int CNT_W = 16,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [AMT_W-1:0] amt_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int SUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum;

  // Clear wins over any increment arriving in the same cycle.
  always_comb begin
    sum     = SUM_W'(count_q) + SUM_W'(amt_i);
    count_d = count_q;
    ovf_o   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (sum > MAX_VAL) begin
      count_d = {CNT_W{1'b1}};
      ovf_o   = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/switch_stats_monitor.sv
// Per-port switch statistics: accepted, dropped packets, dropped copies and
// delivered copies, plus a tracker of copies accepted but not yet delivered.
module switch_stats_monitor
  import packet_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  switch_stats_monitor_if.slave  bus,
  output logic [CNT_W-1:0]       inflight,
  output logic                   sat_flag,
  output logic                   underflow_err
);

  localparam int AMT_W   = $clog2(NUM_PORTS) + 1;
  localparam int IW      = CNT_W + $clog2(NUM_PORTS * NUM_PORTS) + 1;
  localparam int NUM_CNT = NUM_STATS * NUM_PORTS;

  logic [NUM_PORTS-1:0]     acc_ev;
  logic [NUM_PORTS-1:0]     drop_ev;
  logic [NUM_CNT*AMT_W-1:0] amt_flat;
  logic [NUM_CNT*CNT_W-1:0] cnt_flat;
  logic [NUM_CNT-1:0]       cnt_ovf;

  logic [IW-1:0]    add_sum;
  logic [IW-1:0]    sub_sum;
  logic [IW-1:0]    infl_next;
  logic             infl_neg;
  logic             infl_over;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             sat_q, sat_d;
  logic             uf_q, uf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_val;
  stat_sel_e        sel;

  // Counter index layout is stat-major: (stat * NUM_PORTS + port).
  always_comb begin
    acc_ev   = bus.valid_in & ~bus.fifo_full;
    drop_ev  = bus.valid_in & bus.fifo_full;
    amt_flat = '0;
    add_sum  = '0;
    sub_sum  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      amt_flat[(int'(SEL_ACCEPTED)  * NUM_PORTS + p) * AMT_W +: AMT_W] = AMT_W'(acc_ev[p]);
      amt_flat[(int'(SEL_DROPPED)   * NUM_PORTS + p) * AMT_W +: AMT_W] = AMT_W'(drop_ev[p]);
      amt_flat[(int'(SEL_DELIVERED) * NUM_PORTS + p) * AMT_W +: AMT_W] = AMT_W'(bus.valid_out[p]);
      if (drop_ev[p]) begin
        amt_flat[(int'(SEL_DROP_COPIES) * NUM_PORTS + p) * AMT_W +: AMT_W] =
          AMT_W'(popcount16(16'(bus.target_in[p*NUM_PORTS +: NUM_PORTS])));
      end
      if (acc_ev[p]) begin
        add_sum = add_sum + IW'(popcount16(16'(bus.target_in[p*NUM_PORTS +: NUM_PORTS])));
      end
      sub_sum = sub_sum + IW'(bus.valid_out[p]);
    end
  end

  for (genvar s = 0; s < NUM_STATS; s++) begin : g_stat
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      stat_counter #(
        .CNT_W (CNT_W),
        .AMT_W (AMT_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clr),
        .amt_i   (amt_flat[(s*NUM_PORTS + p)*AMT_W +: AMT_W]),
        .count_o (cnt_flat[(s*NUM_PORTS + p)*CNT_W +: CNT_W]),
        .ovf_o   (cnt_ovf[s*NUM_PORTS + p])
      );
    end
  end

  // The in-flight sum is evaluated wide enough that the sign bit reliably flags underflow.
  always_comb begin
    infl_next  = IW'(inflight_q) + add_sum - sub_sum;
    infl_neg   = infl_next[IW-1];
    infl_over  = !infl_neg && (|infl_next[IW-2:CNT_W]);
    inflight_d = infl_next[CNT_W-1:0];
    sat_d      = sat_q | (|cnt_ovf);
    uf_d       = uf_q;
    if (infl_neg) begin
      inflight_d = '0;
      uf_d       = 1'b1;
    end else if (infl_over) begin
      inflight_d = {CNT_W{1'b1}};
      sat_d      = 1'b1;
    end
    if (bus.clr) begin
      inflight_d = '0;
      sat_d      = 1'b0;
      uf_d       = 1'b0;
    end
  end

  // Reads sample the registered counters, so a read alongside clr returns pre-clear data.
  always_comb begin
    sel    = stat_sel_e'(bus.rd_sel);
    rd_val = '0;
    if (int'(bus.rd_port) < NUM_PORTS) begin
      rd_val = cnt_flat[(int'(sel)*NUM_PORTS + int'(bus.rd_port))*CNT_W +: CNT_W];
    end
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      sat_q      <= 1'b0;
      uf_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      sat_q      <= sat_d;
      uf_q       <= uf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign inflight      = inflight_q;
  assign sat_flag      = sat_q;
  assign underflow_err = uf_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_switch_stats_monitor.sv
// Directed bench for switch_stats_monitor: a default 16-bit instance plus a
// 4-bit instance used to reach saturation quickly.
module tb_switch_stats_monitor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [15:0] m_inflight;
  logic        m_sat;
  logic        m_uf;
  logic [3:0]  s_inflight;
  logic        s_sat;
  logic        s_uf;

  switch_stats_monitor_if #(.NUM_PORTS(4), .CNT_W(16)) m_if ();
  switch_stats_monitor_if #(.NUM_PORTS(4), .CNT_W(4))  s_if ();

  switch_stats_monitor #(.NUM_PORTS(4), .CNT_W(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (m_if.slave),
    .inflight      (m_inflight),
    .sat_flag      (m_sat),
    .underflow_err (m_uf)
  );

  switch_stats_monitor #(.NUM_PORTS(4), .CNT_W(4)) u_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (s_if.slave),
    .inflight      (s_inflight),
    .sat_flag      (s_sat),
    .underflow_err (s_uf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    m_if.valid_in  = '0;
    m_if.target_in = '0;
    m_if.fifo_full = '0;
    m_if.valid_out = '0;
    m_if.clr       = 1'b0;
    m_if.rd_en     = 1'b0;
    m_if.rd_port   = '0;
    m_if.rd_sel    = '0;
  endtask

  task automatic idle_small();
    s_if.valid_in  = '0;
    s_if.target_in = '0;
    s_if.fifo_full = '0;
    s_if.valid_out = '0;
    s_if.clr       = 1'b0;
    s_if.rd_en     = 1'b0;
    s_if.rd_port   = '0;
    s_if.rd_sel    = '0;
  endtask

  task automatic read_main(input logic [1:0] port, input logic [1:0] sel,
                           output logic [15:0] data, output logic vld);
    m_if.rd_en   = 1'b1;
    m_if.rd_port = port;
    m_if.rd_sel  = sel;
    tick();
    m_if.rd_en   = 1'b0;
    data = m_if.rd_data;
    vld  = m_if.rd_valid;
  endtask

  task automatic read_small(input logic [1:0] port, input logic [1:0] sel,
                            output logic [3:0] data, output logic vld);
    s_if.rd_en   = 1'b1;
    s_if.rd_port = port;
    s_if.rd_sel  = sel;
    tick();
    s_if.rd_en   = 1'b0;
    data = s_if.rd_data;
    vld  = s_if.rd_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_main();
    idle_small();
    #1;
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL reset_inflight: got %0d expected 0", m_inflight); end
    total++; if (m_sat !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat: got %b expected 0", m_sat); end
    total++; if (m_uf !== 1'b0) begin bad++; $display("[TB] FAIL reset_uf: got %b expected 0", m_uf); end
    total++; if (m_if.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", m_if.rd_valid); end
    total++; if (m_if.rd_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_rd_data: got %0d expected 0", m_if.rd_data); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accept_deliver();
    logic [15:0] d;
    logic        v;
    m_if.valid_in  = 4'b0001;
    m_if.target_in = 16'h0006;
    repeat (5) tick();
    idle_main();
    total++; if (m_inflight !== 16'd10) begin bad++; $display("[TB] FAIL accept_inflight: got %0d expected 10", m_inflight); end
    read_main(2'd0, 2'd0, d, v);
    total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL accept_rd_valid: got %b expected 1", v); end
    total++; if (d !== 16'd5) begin bad++; $display("[TB] FAIL accepted0: got %0d expected 5", d); end
    tick();
    total++; if (m_if.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_valid_drop: got %b expected 0", m_if.rd_valid); end
    total++; if (m_if.rd_data !== 16'd5) begin bad++; $display("[TB] FAIL rd_data_hold: got %0d expected 5", m_if.rd_data); end
    m_if.valid_out = 4'b0110;
    repeat (5) tick();
    idle_main();
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL deliver_inflight: got %0d expected 0", m_inflight); end
    total++; if (m_uf !== 1'b0) begin bad++; $display("[TB] FAIL deliver_uf: got %b expected 0", m_uf); end
    read_main(2'd1, 2'd3, d, v);
    total++; if (d !== 16'd5) begin bad++; $display("[TB] FAIL delivered1: got %0d expected 5", d); end
    read_main(2'd2, 2'd3, d, v);
    total++; if (d !== 16'd5) begin bad++; $display("[TB] FAIL delivered2: got %0d expected 5", d); end
  endtask

  task automatic test_drop();
    logic [15:0] d;
    logic        v;
    m_if.valid_in  = 4'b0100;
    m_if.fifo_full = 4'b0100;
    m_if.target_in = 16'h0B00;
    repeat (3) tick();
    idle_main();
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL drop_inflight: got %0d expected 0", m_inflight); end
    read_main(2'd2, 2'd1, d, v);
    total++; if (d !== 16'd3) begin bad++; $display("[TB] FAIL dropped2: got %0d expected 3", d); end
    read_main(2'd2, 2'd2, d, v);
    total++; if (d !== 16'd9) begin bad++; $display("[TB] FAIL drop_copies2: got %0d expected 9", d); end
    read_main(2'd2, 2'd0, d, v);
    total++; if (d !== 16'd0) begin bad++; $display("[TB] FAIL drop_accepted2: got %0d expected 0", d); end
  endtask

  task automatic test_underflow();
    logic [15:0] d;
    logic        v;
    m_if.valid_out = 4'b0001;
    tick();
    idle_main();
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL uf_inflight: got %0d expected 0", m_inflight); end
    total++; if (m_uf !== 1'b1) begin bad++; $display("[TB] FAIL uf_set: got %b expected 1", m_uf); end
    repeat (3) tick();
    total++; if (m_uf !== 1'b1) begin bad++; $display("[TB] FAIL uf_sticky: got %b expected 1", m_uf); end
    read_main(2'd0, 2'd3, d, v);
    total++; if (d !== 16'd1) begin bad++; $display("[TB] FAIL uf_delivered0: got %0d expected 1", d); end
    m_if.clr = 1'b1;
    tick();
    m_if.clr = 1'b0;
    total++; if (m_uf !== 1'b0) begin bad++; $display("[TB] FAIL uf_clr: got %b expected 0", m_uf); end
    read_main(2'd1, 2'd3, d, v);
    total++; if (d !== 16'd0) begin bad++; $display("[TB] FAIL clr_delivered1: got %0d expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        v;
    m_if.valid_in  = 4'b1111;
    m_if.target_in = 16'hFFFF;
    m_if.valid_out = 4'b1111;
    tick();
    idle_main();
    total++; if (m_inflight !== 16'd12) begin bad++; $display("[TB] FAIL all_inflight: got %0d expected 12", m_inflight); end
    read_main(2'd3, 2'd0, d, v);
    total++; if (d !== 16'd1) begin bad++; $display("[TB] FAIL all_accepted3: got %0d expected 1", d); end
    read_main(2'd2, 2'd3, d, v);
    total++; if (d !== 16'd1) begin bad++; $display("[TB] FAIL all_delivered2: got %0d expected 1", d); end
    m_if.clr = 1'b1;
    read_main(2'd0, 2'd0, d, v);
    m_if.clr = 1'b0;
    total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL rdclr_valid: got %b expected 1", v); end
    total++; if (d !== 16'd1) begin bad++; $display("[TB] FAIL rdclr_data: got %0d expected 1", d); end
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL rdclr_inflight: got %0d expected 0", m_inflight); end
    read_main(2'd0, 2'd0, d, v);
    total++; if (d !== 16'd0) begin bad++; $display("[TB] FAIL rdclr_after: got %0d expected 0", d); end
  endtask

  task automatic test_saturation();
    logic [3:0] d;
    logic       v;
    s_if.valid_in  = 4'b1000;
    s_if.target_in = 16'h0000;
    repeat (15) tick();
    total++; if (s_sat !== 1'b0) begin bad++; $display("[TB] FAIL sat_at_max: got %b expected 0", s_sat); end
    total++; if (s_inflight !== 4'd0) begin bad++; $display("[TB] FAIL zero_mask_inflight: got %0d expected 0", s_inflight); end
    tick();
    idle_small();
    total++; if (s_sat !== 1'b1) begin bad++; $display("[TB] FAIL sat_set: got %b expected 1", s_sat); end
    read_small(2'd3, 2'd0, d, v);
    total++; if (d !== 4'd15) begin bad++; $display("[TB] FAIL sat_accepted3: got %0d expected 15", d); end
    s_if.clr = 1'b1;
    tick();
    s_if.clr = 1'b0;
    total++; if (s_sat !== 1'b0) begin bad++; $display("[TB] FAIL sat_clr: got %b expected 0", s_sat); end
    read_small(2'd3, 2'd0, d, v);
    total++; if (d !== 4'd0) begin bad++; $display("[TB] FAIL sat_clr_count: got %0d expected 0", d); end
    s_if.valid_in  = 4'b1111;
    s_if.target_in = 16'hFFFF;
    tick();
    idle_small();
    total++; if (s_inflight !== 4'd15) begin bad++; $display("[TB] FAIL inflight_sat: got %0d expected 15", s_inflight); end
    total++; if (s_sat !== 1'b1) begin bad++; $display("[TB] FAIL inflight_sat_flag: got %b expected 1", s_sat); end
    s_if.clr = 1'b1;
    tick();
    s_if.clr = 1'b0;
    total++; if (s_inflight !== 4'd0) begin bad++; $display("[TB] FAIL inflight_sat_clr: got %0d expected 0", s_inflight); end
  endtask

  task automatic test_reset_midburst();
    logic [15:0] d;
    logic        v;
    m_if.valid_in  = 4'b0001;
    m_if.target_in = 16'h0001;
    repeat (7) tick();
    total++; if (m_inflight !== 16'd7) begin bad++; $display("[TB] FAIL burst_inflight: got %0d expected 7", m_inflight); end
    read_main(2'd0, 2'd0, d, v);
    total++; if (d !== 16'd7) begin bad++; $display("[TB] FAIL burst_accepted0: got %0d expected 7", d); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (m_inflight !== 16'd0) begin bad++; $display("[TB] FAIL async_inflight: got %0d expected 0", m_inflight); end
    total++; if (m_if.rd_data !== 16'd0) begin bad++; $display("[TB] FAIL async_rd_data: got %0d expected 0", m_if.rd_data); end
    total++; if (m_if.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_rd_valid: got %b expected 0", m_if.rd_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    m_if.valid_in = 4'b0000;
    read_main(2'd0, 2'd0, d, v);
    total++; if (d !== 16'd3) begin bad++; $display("[TB] FAIL post_reset_accepted0: got %0d expected 3", d); end
    total++; if (m_inflight !== 16'd3) begin bad++; $display("[TB] FAIL post_reset_inflight: got %0d expected 3", m_inflight); end
    total++; if (m_sat !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_sat: got %b expected 0", m_sat); end
    idle_main();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_accept_deliver();
    test_drop();
    test_underflow();
    test_back_to_back();
    test_saturation();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
